// File: rtl/burst_buf_param.sv
`default_nettype none
// ============================================================================
// Module   : burst_buf_param
// Purpose  : Enable-framed burst capture/replay buffer with FIFO or LIFO
//            drain, downstream stall, fill level, sticky overflow and done.
// Option   : BURST_BUF_PARITY_EN adds per-word even parity, par_err output
//            and the force_perr test input.
// Revision : 1.0  initial release
// ============================================================================
module burst_buf_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             e_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode_lifo,
    input  logic             out_ready,
    output logic             e_out,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    level,
    output logic             busy,
    output logic             ovf,
    output logic             done
`ifdef BURST_BUF_PARITY_EN
    ,
    input  logic             force_perr,
    output logic             par_err
`endif
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE    = CW'(1);
    localparam logic [CW:0]   C_RD_ONE = (CW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_level, w_level_nxt;
    logic [CW-1:0]    r_rem, w_rem_nxt;
    // One bit wider than the count so the LIFO pointer can step past entry 0
    logic [CW:0]      r_rd, w_rd_nxt;
    logic             r_lifo, w_lifo_nxt;
    logic             r_e_out, w_e_out_nxt;
    logic [WIDTH-1:0] r_data_out, w_data_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_done, w_done_nxt;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic [WIDTH-1:0] w_rd_data;

    assign w_rd_idx  = r_rd[AW-1:0];
    assign w_rd_data = r_mem[w_rd_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_rem_nxt   = r_rem;
        w_rd_nxt    = r_rd;
        w_lifo_nxt  = r_lifo;
        w_e_out_nxt = 1'b0;
        w_data_nxt  = '0;
        w_busy_nxt  = r_busy;
        w_ovf_nxt   = r_ovf;
        w_done_nxt  = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = '0;
        case (r_state)
            S_IDLE: begin
                if (e_in) begin
                    w_wr_en     = 1'b1;
                    w_level_nxt = C_ONE;
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (e_in) begin
                    if (r_level < C_DEPTH) begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = r_level[AW-1:0];
                        w_level_nxt = r_level + C_ONE;
                    end else begin
                        w_ovf_nxt   = 1'b1;
                    end
                end else begin
                    w_lifo_nxt  = mode_lifo;
                    w_rd_nxt    = mode_lifo ? ({1'b0, r_level} - C_RD_ONE) : '0;
                    w_rem_nxt   = r_level;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_rem == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (out_ready) begin
                    w_e_out_nxt = 1'b1;
                    w_data_nxt  = w_rd_data;
                    w_rd_nxt    = r_lifo ? (r_rd - C_RD_ONE) : (r_rd + C_RD_ONE);
                    w_rem_nxt   = r_rem - C_ONE;
                    w_level_nxt = r_level - C_ONE;
                end else begin
                    // Stall bubble keeps the previous word on the bus
                    w_data_nxt  = r_data_out;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_level    <= '0;
            r_rem      <= '0;
            r_rd       <= '0;
            r_lifo     <= 1'b0;
            r_e_out    <= 1'b0;
            r_data_out <= '0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_rem      <= w_rem_nxt;
            r_rd       <= w_rd_nxt;
            r_lifo     <= w_lifo_nxt;
            r_e_out    <= w_e_out_nxt;
            r_data_out <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_ovf      <= w_ovf_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

`ifdef BURST_BUF_PARITY_EN
    logic r_par [DEPTH];
    logic r_par_err;
    logic w_par_err_nxt;

    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_par[w_wr_idx] <= (^data_in) ^ force_perr;
        end
    end

    assign w_par_err_nxt = w_e_out_nxt & ((^w_rd_data) != r_par[w_rd_idx]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_nxt;
        end
    end

    assign par_err = r_par_err;
`endif

    assign e_out    = r_e_out;
    assign data_out = r_data_out;
    assign level    = r_level;
    assign busy     = r_busy;
    assign ovf      = r_ovf;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_burst_buf_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_buf_param
// Purpose  : Scoreboard bench for burst_buf_param (WIDTH=8, DEPTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_burst_buf_param;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             e_in = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             mode_lifo = 1'b0;
    logic             out_ready = 1'b1;
    logic             e_out;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    level;
    logic             busy;
    logic             ovf;
    logic             done;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] exp_w;
    bit               sb_lifo = 1'b0;

    logic [CW-1:0]    fill_lvl [16];
    logic             fill_ovf [16];
    logic [31:0]      obs_pat;
    logic [WIDTH-1:0] obs_d    [32];
    logic [CW-1:0]    obs_lvl  [32];
    logic             obs_busy [32];
    int               done_k;

    burst_buf_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .e_in      (e_in),
        .data_in   (data_in),
        .mode_lifo (mode_lifo),
        .out_ready (out_ready),
        .e_out     (e_out),
        .data_out  (data_out),
        .level     (level),
        .busy      (busy),
        .ovf       (ovf),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: every valid output word is matched against the queue
    always @(negedge CLK) begin
        if (!RST && e_out) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra_word: got=%h want=none", data_out);
            end else begin
                exp_w = sb_lifo ? exp_q.pop_back() : exp_q.pop_front();
                if (data_out !== exp_w) begin
                    bad++;
                    $display("FAIL sb_data: got=%h want=%h", data_out, exp_w);
                end
            end
        end
    end

    task automatic drive_burst(input int n, input logic [7:0] base, input logic [7:0] step,
                               input bit lifo, input bit now);
        logic [7:0] w;
        w         = base;
        sb_lifo   = lifo;
        mode_lifo = lifo;
        for (int i = 0; i < n; i++) begin
            if (!(now && i == 0)) @(negedge CLK);
            fill_lvl[i] = level;
            fill_ovf[i] = ovf;
            e_in        = 1'b1;
            data_in     = w;
            if (i < DEPTH) exp_q.push_back(w);
            w = w + step;
        end
        @(negedge CLK);
        fill_lvl[n] = level;
        fill_ovf[n] = ovf;
        e_in        = 1'b0;
        data_in     = '0;
    endtask

    task automatic collect(input int stall_edge, input int pulse_at);
        done_k  = -1;
        obs_pat = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            obs_pat[k]  = e_out;
            obs_d[k]    = data_out;
            obs_lvl[k]  = level;
            obs_busy[k] = busy;
            e_in        = (k == pulse_at);
            data_in     = (k == pulse_at) ? 8'hEE : 8'h00;
            out_ready   = ((k + 1) != stall_edge);
            if (done) begin
                done_k = k;
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 RST = 1'b1;
        #1;
        total++; if (e_out !== 1'b0)    begin bad++; $display("FAIL rst_e_out: got=%b want=0", e_out); end
        total++; if (data_out !== 8'h0) begin bad++; $display("FAIL rst_data: got=%h want=00", data_out); end
        total++; if (level !== 3'd0)    begin bad++; $display("FAIL rst_level: got=%0d want=0", level); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy: got=%b want=0", busy); end
        total++; if (ovf !== 1'b0)      begin bad++; $display("FAIL rst_ovf: got=%b want=0", ovf); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL rst_done: got=%b want=0", done); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_fifo();
        drive_burst(4, 8'h11, 8'h11, 1'b0, 1'b0);
        total++; if (fill_lvl[4] !== 3'd4) begin bad++; $display("FAIL fifo_fill_level: got=%0d want=4", fill_lvl[4]); end
        collect(0, -1);
        total++; if (obs_busy[0] !== 1'b1) begin bad++; $display("FAIL fifo_busy: got=%b want=1", obs_busy[0]); end
        total++; if (obs_pat !== 32'h1E) begin bad++; $display("FAIL fifo_e_out_pattern: got=%h want=0000001e", obs_pat); end
        total++;
        if ({obs_lvl[1], obs_lvl[2], obs_lvl[3], obs_lvl[4]} !== {3'd3, 3'd2, 3'd1, 3'd0}) begin
            bad++;
            $display("FAIL fifo_level_steps: got=%0d,%0d,%0d,%0d want=3,2,1,0",
                     obs_lvl[1], obs_lvl[2], obs_lvl[3], obs_lvl[4]);
        end
        total++; if (done_k !== 5) begin bad++; $display("FAIL fifo_done_cycle: got=%0d want=5", done_k); end
        total++; if (data_out !== 8'h0) begin bad++; $display("FAIL fifo_data_after: got=%h want=00", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fifo_busy_done: got=%b want=0", busy); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fifo_words_left: got=%0d want=0", exp_q.size()); end
        @(negedge CLK);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fifo_done_clear: got=%b want=0", done); end
    endtask

    task automatic test_lifo();
        drive_burst(4, 8'h11, 8'h11, 1'b1, 1'b0);
        collect(0, -1);
        total++; if (obs_pat !== 32'h1E) begin bad++; $display("FAIL lifo_e_out_pattern: got=%h want=0000001e", obs_pat); end
        total++; if (done_k !== 5) begin bad++; $display("FAIL lifo_done_cycle: got=%0d want=5", done_k); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL lifo_words_left: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_overflow();
        drive_burst(6, 8'h01, 8'h01, 1'b0, 1'b0);
        total++; if (fill_lvl[5] !== 3'd4) begin bad++; $display("FAIL ovf_level5: got=%0d want=4", fill_lvl[5]); end
        total++; if (fill_lvl[6] !== 3'd4) begin bad++; $display("FAIL ovf_level6: got=%0d want=4", fill_lvl[6]); end
        total++; if (fill_ovf[4] !== 1'b0) begin bad++; $display("FAIL ovf_early: got=%b want=0", fill_ovf[4]); end
        total++; if (fill_ovf[5] !== 1'b1) begin bad++; $display("FAIL ovf_set: got=%b want=1", fill_ovf[5]); end
        collect(0, -1);
        total++; if (obs_pat !== 32'h1E) begin bad++; $display("FAIL ovf_e_out_pattern: got=%h want=0000001e", obs_pat); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got=%b want=1", ovf); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_words_left: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        drive_burst(3, 8'hA0, 8'h01, 1'b0, 1'b0);
        collect(2, -1);
        total++; if (obs_pat !== 32'h1A) begin bad++; $display("FAIL stall_e_out_pattern: got=%h want=0000001a", obs_pat); end
        total++; if (obs_d[2] !== 8'hA0) begin bad++; $display("FAIL stall_hold: got=%h want=a0", obs_d[2]); end
        total++; if (done_k !== 5) begin bad++; $display("FAIL stall_done_cycle: got=%0d want=5", done_k); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL stall_ovf_cleared: got=%b want=0", ovf); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stall_words_left: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_drain();
        drive_burst(3, 8'h10, 8'h10, 1'b0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        total++; if (e_out !== 1'b1) begin bad++; $display("FAIL rmid_first_word: got=%b want=1", e_out); end
        #2 RST = 1'b1;
        #1;
        total++;
        if ({e_out, data_out, level, busy, ovf, done} !== '0) begin
            bad++;
            $display("FAIL rmid_async_clear: got e_out=%b data=%h level=%0d busy=%b ovf=%b done=%b want all 0",
                     e_out, data_out, level, busy, ovf, done);
        end
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        drive_burst(1, 8'h5A, 8'h00, 1'b0, 1'b0);
        collect(0, -1);
        total++; if (obs_pat !== 32'h2) begin bad++; $display("FAIL rmid_single_pattern: got=%h want=00000002", obs_pat); end
        total++; if (done_k !== 2) begin bad++; $display("FAIL rmid_done_cycle: got=%0d want=2", done_k); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL rmid_ovf: got=%b want=0", ovf); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_words_left: got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        drive_burst(3, 8'h31, 8'h01, 1'b0, 1'b0);
        collect(0, 2);
        total++; if (obs_busy[2] !== 1'b1) begin bad++; $display("FAIL b2b_busy_pulse: got=%b want=1", obs_busy[2]); end
        total++; if (obs_busy[3] !== 1'b1) begin bad++; $display("FAIL b2b_busy_after: got=%b want=1", obs_busy[3]); end
        total++; if (obs_pat !== 32'hE) begin bad++; $display("FAIL b2b_e_out_pattern: got=%h want=0000000e", obs_pat); end
        total++; if (done_k !== 4) begin bad++; $display("FAIL b2b_done_cycle: got=%0d want=4", done_k); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf: got=%b want=0", ovf); end
        drive_burst(1, 8'h77, 8'h00, 1'b0, 1'b1);
        total++; if (fill_lvl[1] !== 3'd1) begin bad++; $display("FAIL b2b_capture_level: got=%0d want=1", fill_lvl[1]); end
        collect(0, -1);
        total++; if (obs_pat !== 32'h2) begin bad++; $display("FAIL b2b_refill_pattern: got=%h want=00000002", obs_pat); end
        total++; if (done_k !== 2) begin bad++; $display("FAIL b2b_refill_done: got=%0d want=2", done_k); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_words_left: got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_fifo();
        test_lifo();
        test_overflow();
        test_stall();
        test_reset_mid_drain();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/burst_buf_param.md
Name: burst_buf_param

Overview:
- Parametrised burst capture/replay buffer; next generation of the 4-entry, 8-bit enable-framed burst buffer.
- Captures a burst of up to DEPTH words while e_in is high, then drains it on e_out/data_out once e_in drops.
- Drain order is selectable per burst (FIFO or LIFO). Adds a downstream stall input, a fill-level output, sticky overflow and a done pulse.
- Sits between a framed burst producer and a consumer that accepts one word per e_out cycle.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, storage entries (>=2); CW = $clog2(DEPTH+1) is the count width

Ports:
CLK  input  1  rising-edge clock
RST  input  1  asynchronous, active-high reset
e_in  input  1  burst frame; high = data_in valid this cycle
data_in  input  WIDTH  write data
mode_lifo  input  1  0 = FIFO drain order, 1 = LIFO; sampled on the FILL->DRAIN edge
out_ready  input  1  consumer ready; 0 inserts a bubble in DRAIN
e_out  output  1  data_out valid
data_out  output  WIDTH  read data; 0 when e_out is low, except during stall hold (see Behaviour)
level  output  CW  words currently stored
busy  output  1  high in DRAIN; e_in is ignored while busy
ovf  output  1  sticky: a write was dropped in the current or last burst
done  output  1  one-cycle pulse after the last word of a drain

Behaviour:
- Reset is asynchronous, active-high. Any assertion, including mid-burst:
  - state=IDLE; e_out=0, data_out=0, level=0, busy=0, ovf=0, done=0.
  - Storage contents are not reset; they are don't-care.
- States: IDLE, FILL, DRAIN. All outputs are registered.
- IDLE:
  - e_in=1 at an edge: write data_in to entry 0, level<=1, ovf<=0, go FILL.
  - e_in=0: stay IDLE.
- FILL:
  - e_in=1 and level<DEPTH: write data_in to entry level, level<=level+1.
  - e_in=1 and level==DEPTH: word dropped, ovf<=1, level unchanged.
  - e_in=0: latch mode_lifo, set rd pointer (FIFO: 0; LIFO: level-1), busy<=1, go DRAIN.
  - Remaining-count register <= level.
  - FILL is only reached with level>=1, so a zero-length drain cannot occur.
- DRAIN, at each edge:
  - out_ready=1 and remaining>0:
    - e_out<=1, data_out<=mem[rd].
    - FIFO: rd++. LIFO: rd--.
    - remaining--, level<=level-1.
  - out_ready=0: e_out<=0; data_out holds its last value; no pointer or count change.
  - remaining==0: e_out<=0, data_out<=0, done<=1, busy<=0, go IDLE.
  - done clears on the following edge.
- Latency: the first word appears on e_out one edge after the edge where e_in is sampled low.
  - An N-word burst with out_ready held high gives N consecutive e_out cycles, then done.
- e_in during DRAIN is ignored; words are lost without setting ovf. The producer must respect busy.
- e_in may rise in the same cycle done is high. That edge is in IDLE, so the new burst is captured.
- Pointers never wrap: FIFO rd ends at level, LIFO rd ends at -1. The pointer must be CW+1 bits wide, or the read must be guarded by remaining.
- ovf is cleared only at the start of the next burst or by reset.

Optional Feature:
- Macro: BURST_BUF_PARITY_EN.
- Defined:
  - Each stored word carries an even-parity bit computed on write.
  - New output par_err (1 bit) is registered with e_out. It is 1 when the recomputed parity of the word read does not match the stored bit.
  - Reset value of par_err is 0; it is 0 whenever e_out=0.
  - A hidden force_perr input, for test only, inverts the stored parity bit on write.
- Undefined: the par_err and force_perr ports are absent, no parity storage exists, and behaviour is otherwise identical.

Test Plan:
- WIDTH=8, DEPTH=4, FIFO, out_ready=1; e_in high for 4 cycles with 0x11,0x22,0x33,0x44, then low -> e_out high for 4 cycles with 0x11,0x22,0x33,0x44; done pulses the next cycle; level steps 4,3,2,1,0; data_out=0 afterwards.
- Same burst with mode_lifo=1 -> outputs 0x44,0x33,0x22,0x11.
- 6-word burst 0x01..0x06, FIFO -> ovf=1; only 0x01..0x04 output; level stays 4 during the last two write cycles.
- FIFO 3-word burst 0xA0,0xA1,0xA2 with out_ready low on the 2nd DRAIN edge -> e_out pattern 1,0,1,1; data 0xA0, 0xA0 held, 0xA1, 0xA2; then done.
- RST pulsed during DRAIN after one word -> all outputs 0 immediately, without waiting for a clock edge. Next burst 0x5A alone -> single output 0x5A with ovf=0.
- e_in pulsed during DRAIN -> busy=1 and the pulse is ignored. e_in raised in the done cycle with 0x77 -> captured, drained as 0x77.
